// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave frame engine feeding a single-port RAM, with read sequencing and error reporting.
// Ports: clk/rst (async active-high) | SS_n, MOSI serial in | tx_valid, tx_data RAM read data |
//        MISO serial out | rx_valid/rx_data received command word | frame_err abort/mismatch/timeout | busy
module spi_slave_param #(
  parameter int PAYLOAD_W  = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic                 tx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  output logic                 MISO,
  output logic                 rx_valid,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int RX_W    = PAYLOAD_W + 2;
  localparam int CNT_MAX = RX_W > TX_TIMEOUT ? RX_W : TX_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef enum logic [2:0] {IDLE, CHK_CMD, RX, WAIT_TX, SEND, DONE} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RX_W-1:0]      rx_sr_q, rx_sr_d, rx_data_q, rx_data_d, rx_word;
  logic [PAYLOAD_W-1:0] tx_sr_q, tx_sr_d;
  logic                 dir_q, dir_d, read_state_q, read_state_d, miso_q, miso_d;
  logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, abort;
  logic [1:0]           cmd;
  always_comb begin
    rx_word      = LSB_FIRST ? {MOSI, rx_sr_q[RX_W-1:1]} : {rx_sr_q[RX_W-2:0], MOSI};
    cmd          = rx_word[RX_W-1:RX_W-2];
    abort        = SS_n && (state_q inside {CHK_CMD, RX, WAIT_TX, SEND});
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_sr_d      = rx_sr_q;
    rx_data_d    = rx_data_q;
    tx_sr_d      = tx_sr_q;
    dir_d        = dir_q;
    read_state_d = read_state_q;
    miso_d       = 1'b0;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE:    state_d = SS_n ? IDLE : CHK_CMD;
        CHK_CMD: begin
          dir_d   = MOSI;
          state_d = RX;
        end
        RX: begin
          rx_sr_d = rx_word;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(RX_W - 1)) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = DONE;
            // read-data is only legal once a read-addr has been accepted
            if (dir_q != cmd[1]) frame_err_d = 1'b1;
            else if (cmd == 2'b10) read_state_d = 1'b1;
            else if (cmd == 2'b11) begin
              if (read_state_q) state_d = WAIT_TX;
              else frame_err_d = 1'b1;
            end
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            tx_sr_d = tx_data;
            cnt_d   = '0;
            state_d = SEND;
          end else if (cnt_q == CNT_W'(TX_TIMEOUT - 1)) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = DONE;
          end else cnt_d = cnt_q + 1'b1;
        end
        SEND: begin
          // one extra edge after the last bit returns MISO to 0 before DONE
          if (cnt_q == CNT_W'(PAYLOAD_W)) begin
            read_state_d = 1'b0;
            cnt_d        = '0;
            state_d      = DONE;
          end else begin
            miso_d  = LSB_FIRST ? tx_sr_q[0] : tx_sr_q[PAYLOAD_W-1];
            tx_sr_d = LSB_FIRST ? tx_sr_q >> 1 : tx_sr_q << 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = SS_n ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rx_sr_q      <= '0;
      rx_data_q    <= '0;
      tx_sr_q      <= '0;
      dir_q        <= 1'b0;
      read_state_q <= 1'b0;
      miso_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_sr_q      <= rx_sr_d;
      rx_data_q    <= rx_data_d;
      tx_sr_q      <= tx_sr_d;
      dir_q        <= dir_d;
      read_state_q <= read_state_d;
      miso_q       <= miso_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end
  assign MISO      = miso_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign busy      = state_q != IDLE;
endmodule
